nn_system_top: RTL and testbench

Two-layer, 4-neuron fixed-point matrix-vector engine: on `start`, each layer fetches one input vector and N weight vectors from external asynchronous-read BRAMs. It computes N dot products in parallel on N_MACS MAC lanes and reports each layer's results via `valid_out`. It sits between the BRAM/host control plane and downstream result consumers as the top of the NN datapath.

---
 rtl/nn_pkg.sv | 20 ++
 rtl/nn_system_top_mac.sv | 42 ++++
 rtl/nn_system_top.sv | 194 +++++++++++++++++++
 tb/tb_nn_system_top.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the two-layer NN matrix-vector engine.
package nn_pkg;

  localparam int N_DEF           = 4;
  localparam int LANE_W          = 16;
  localparam int BRAM_W          = 4 * LANE_W;
  localparam int AW              = $clog2(256);
  localparam int LAYER1_W_OFFSET = N_DEF;
  localparam int LAYER1_I_OFFSET = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_W,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } nn_state_e;

endpackage

// File: rtl/nn_system_top_mac.sv
// One signed multiply-accumulate lane with synchronous clear; the accumulator
// wraps modulo 2^ACC_W. sum_o is the value the accumulator takes at the next edge.
module nn_mac #(
  parameter int W     = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     b_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    prod  = a_i * b_i;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  assign sum_o = acc_d;

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/nn_system_top.sv
// Two-layer, 4-neuron fixed-point matrix-vector engine.
// Optional feature macro: NN_RELU_EN (clamp negative results to zero).
module nn_system_top
  import nn_pkg::*;
#(
  parameter int W         = 8,
  parameter int ACC_W     = 16,
  parameter int N_MACS    = 4,
  parameter int N         = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear_all,
  output logic [$clog2(MEM_DEPTH)-1:0] weight_bram_addr,
  output logic                         weight_bram_en,
  input  logic [4*ACC_W-1:0]           weight_bram_dout,
  output logic [$clog2(MEM_DEPTH)-1:0] input_bram_addr,
  output logic                         input_bram_en,
  input  logic [4*ACC_W-1:0]           input_bram_dout,
  output logic                         busy,
  output logic                         done,
  output logic signed [ACC_W-1:0]      acc_out_0,
  output logic signed [ACC_W-1:0]      acc_out_1,
  output logic signed [ACC_W-1:0]      acc_out_2,
  output logic signed [ACC_W-1:0]      acc_out_3,
  output logic [N_MACS-1:0]            valid_out
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CW     = (N > 1) ? $clog2(N) : 1;

  nn_state_e               state_q;
  logic                    layer_q;
  logic [CW-1:0]           cnt_q;
  logic signed [W-1:0]     x_q [N];
  logic signed [W-1:0]     w_q [N][N];
  logic [ADDR_W-1:0]       w_addr_q;
  logic [ADDR_W-1:0]       i_addr_q;
  logic                    w_en_q;
  logic                    i_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic [N_MACS-1:0]       valid_q;
  logic signed [ACC_W-1:0] acc_out_q [N];
  logic signed [ACC_W-1:0] mac_sum [N_MACS];
  logic                    mac_clr;
  logic                    mac_en;
  logic                    last_cnt;
  logic                    unused_dout;

  function automatic logic signed [ACC_W-1:0] post(input logic signed [ACC_W-1:0] v);
`ifdef NN_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Only the low W bits of each BRAM lane carry an operand.
  assign unused_dout = ^{weight_bram_dout, input_bram_dout};

  // Accumulators clear on the edge that enters COMPUTE and accumulate during it.
  assign last_cnt = (cnt_q == CW'(N - 1));
  assign mac_clr  = (state_q == S_LOAD_W) && last_cnt;
  assign mac_en   = (state_q == S_COMPUTE);

  for (genvar j = 0; j < N_MACS; j++) begin : g_mac
    nn_mac #(
      .W     (W),
      .ACC_W (ACC_W)
    ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr_i (mac_clr),
      .en_i  (mac_en),
      .a_i   (x_q[cnt_q]),
      .b_i   (w_q[j][cnt_q]),
      .sum_o (mac_sum[j])
    );
  end

  // Sequencer with registered outputs; addresses and enables are set on the
  // edge entering each load cycle so the asynchronous BRAMs answer in-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layer_q  <= 1'b0;
      cnt_q    <= '0;
      w_addr_q <= '0;
      i_addr_q <= '0;
      w_en_q   <= 1'b0;
      i_en_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        x_q[i]       <= '0;
        acc_out_q[i] <= '0;
        for (int unsigned k = 0; k < N; k++) begin
          w_q[i][k] <= '0;
        end
      end
    end else begin
      w_en_q  <= 1'b0;
      i_en_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (clear_all) begin
            for (int unsigned i = 0; i < N; i++) begin
              acc_out_q[i] <= '0;
            end
          end
          if (start) begin
            state_q  <= S_LOAD_X;
            layer_q  <= 1'b0;
            busy_q   <= 1'b1;
            i_en_q   <= 1'b1;
            i_addr_q <= '0;
          end
        end
        S_LOAD_X: begin
          for (int unsigned k = 0; k < N; k++) begin
            x_q[k] <= input_bram_dout[k*ACC_W +: W];
          end
          state_q  <= S_LOAD_W;
          cnt_q    <= '0;
          w_en_q   <= 1'b1;
          w_addr_q <= layer_q ? ADDR_W'(LAYER1_W_OFFSET) : '0;
        end
        S_LOAD_W: begin
          for (int unsigned k = 0; k < N; k++) begin
            w_q[cnt_q][k] <= weight_bram_dout[k*ACC_W +: W];
          end
          if (last_cnt) begin
            state_q <= S_COMPUTE;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= cnt_q + CW'(1);
            w_en_q   <= 1'b1;
            w_addr_q <= w_addr_q + ADDR_W'(1);
          end
        end
        S_COMPUTE: begin
          if (last_cnt) begin
            state_q <= S_OUTPUT;
            cnt_q   <= '0;
            valid_q <= '1;
            for (int unsigned j = 0; j < N_MACS; j++) begin
              acc_out_q[j] <= post(mac_sum[j]);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_OUTPUT: begin
          if (!layer_q) begin
            state_q  <= S_LOAD_X;
            layer_q  <= 1'b1;
            i_en_q   <= 1'b1;
            i_addr_q <= ADDR_W'(LAYER1_I_OFFSET);
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign weight_bram_addr = w_addr_q;
  assign weight_bram_en   = w_en_q;
  assign input_bram_addr  = i_addr_q;
  assign input_bram_en    = i_en_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign valid_out        = valid_q;
  assign acc_out_0        = acc_out_q[0];
  assign acc_out_1        = acc_out_q[1];
  assign acc_out_2        = acc_out_q[2];
  assign acc_out_3        = acc_out_q[3];

endmodule

// File: tb/tb_nn_system_top.sv
// Self-checking bench for nn_system_top: cycle-accurate reference model,
// literal pins on directed runs, randomized memories and control noise.
module tb_nn_system_top;

  localparam int W     = 8;
  localparam int ACC_W = 16;
  localparam int N     = 4;
  localparam int NM    = 4;
  localparam int MD    = 256;
  localparam int AW    = 8;
  localparam int BW    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, start, clear_all;
  logic [AW-1:0]           waddr, iaddr;
  logic                    wen, ien;
  logic [BW-1:0]           wdout, idout;
  logic                    busy, done;
  logic signed [ACC_W-1:0] a0, a1, a2, a3;
  logic [NM-1:0]           vout;
  logic signed [ACC_W-1:0] accv [4];

  logic [BW-1:0] wmem [MD];
  logic [BW-1:0] imem [MD];

  assign wdout   = wmem[waddr];
  assign idout   = imem[iaddr];
  assign accv[0] = a0;
  assign accv[1] = a1;
  assign accv[2] = a2;
  assign accv[3] = a3;

  nn_system_top #(
    .W         (W),
    .ACC_W     (ACC_W),
    .N_MACS    (NM),
    .N         (N),
    .MEM_DEPTH (MD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .clear_all        (clear_all),
    .weight_bram_addr (waddr),
    .weight_bram_en   (wen),
    .weight_bram_dout (wdout),
    .input_bram_addr  (iaddr),
    .input_bram_en    (ien),
    .input_bram_dout  (idout),
    .busy             (busy),
    .done             (done),
    .acc_out_0        (a0),
    .acc_out_1        (a1),
    .acc_out_2        (a2),
    .acc_out_3        (a3),
    .valid_out        (vout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 60)
        $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // run_t = cycles since the edge that accepted start (-1 when idle).
  int                      run_t = -1;
  logic signed [ACC_W-1:0] m_acc [4];
  int                      m_iaddr = 0;
  int                      m_waddr = 0;

  function automatic logic signed [ACC_W-1:0] ref_result(input int layer, input int j);
    int          s;
    logic [15:0] xl, wl;
    logic [63:0] xw, ww;
    logic signed [15:0] r;
    s  = 0;
    xw = imem[layer];
    ww = wmem[layer*4 + j];
    for (int k = 0; k < 4; k++) begin
      xl = xw[k*16 +: 16];
      wl = ww[k*16 +: 16];
      s += int'($signed(xl[7:0])) * int'($signed(wl[7:0]));
    end
    r = s[15:0];
`ifdef NN_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  initial for (int j = 0; j < 4; j++) m_acc[j] = '0;

  // Compare current outputs against the model, then advance the model using
  // the inputs the coming rising edge will sample.
  always @(negedge clk) begin
    if (rst) begin
      run_t   = -1;
      m_iaddr = 0;
      m_waddr = 0;
      for (int j = 0; j < 4; j++) m_acc[j] = '0;
    end
    chk("busy", busy, (run_t >= 0 && run_t <= 19));
    chk("done", done, (run_t == 20));
    chk("valid_out", vout, (run_t == 9 || run_t == 19) ? 15 : 0);
    chk("input_en", ien, (run_t == 0 || run_t == 10));
    chk("weight_en", wen, ((run_t >= 1 && run_t <= 4) || (run_t >= 11 && run_t <= 14)));
    chk("input_addr", iaddr, m_iaddr);
    chk("weight_addr", waddr, m_waddr);
    for (int j = 0; j < 4; j++) chk($sformatf("acc_out_%0d", j), accv[j], m_acc[j]);
    if (!rst) begin
      if (run_t < 0) begin
        if (clear_all) for (int j = 0; j < 4; j++) m_acc[j] = '0;
        if (start) run_t = 0;
      end else begin
        run_t++;
        if (run_t == 21) run_t = -1;
      end
      if (run_t == 0)  m_iaddr = 0;
      if (run_t == 10) m_iaddr = 1;
      if (run_t >= 1 && run_t <= 4)   m_waddr = run_t - 1;
      if (run_t >= 11 && run_t <= 14) m_waddr = run_t - 7;
      if (run_t == 9)  for (int j = 0; j < 4; j++) m_acc[j] = ref_result(0, j);
      if (run_t == 19) for (int j = 0; j < 4; j++) m_acc[j] = ref_result(1, j);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    logic [63:0] r;
    r[15:0]  = 16'(a);
    r[31:16] = 16'(b);
    r[47:32] = 16'(c);
    r[63:48] = 16'(d);
    return r;
  endfunction

  function automatic logic [63:0] diag(input int j, input int v);
    return pk((j == 0) ? v : 0, (j == 1) ? v : 0, (j == 2) ? v : 0, (j == 3) ? v : 0);
  endfunction

  // Called at posedge+2 while idle; returns at posedge+2 of cycle E+21 (idle).
  task automatic do_run(input bit noise, input bit clr, input bit lit,
                        input int e0 [4], input int e1 [4]);
    start     = 1'b1;
    clear_all = clr;
    @(posedge clk);
    #2;
    start     = 1'b0;
    clear_all = 1'b0;
    for (int t = 1; t <= 21; t++) begin
      @(posedge clk);
      #2;
      if (noise && t <= 19) begin
        start     = 1'($urandom_range(0, 1));
        clear_all = 1'($urandom_range(0, 1));
      end else begin
        start     = 1'b0;
        clear_all = 1'b0;
      end
      if (lit && (t == 9 || t == 19)) begin
        #1;
        chk("lit_valid", vout, 15);
        for (int j = 0; j < 4; j++)
          chk($sformatf("lit_L%0d_acc%0d", (t == 9) ? 0 : 1, j), accv[j], (t == 9) ? e0[j] : e1[j]);
      end
      if (lit && t == 20) begin
        #1;
        chk("lit_done", done, 1);
        chk("lit_busy_at_done", busy, 0);
      end
    end
  endtask

  int id [4] = '{1, 2, 3, 4};
  int d2 [4] = '{2, 4, 6, 8};
  int ng [4];
  int wr [4];
  int zz [4] = '{0, 0, 0, 0};

  initial begin
`ifdef NN_RELU_EN
    ng = '{0, 0, 0, 0};
    wr = '{0, 0, 0, 0};
`else
    ng = '{-10, -10, -10, -10};
    wr = '{-1020, -1020, -1020, -1020};
`endif
    rst = 1'b1; start = 1'b0; clear_all = 1'b0;
    for (int a = 0; a < MD; a++) begin
      wmem[a] = '0;
      imem[a] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_acc0", a0, 0);
    chk("reset_valid", vout, 0);

    // Both layers identity, with ignored start/clear noise mid-run.
    imem[0] = pk(1, 2, 3, 4);
    imem[1] = pk(1, 2, 3, 4);
    for (int j = 0; j < 4; j++) begin
      wmem[j]     = diag(j, 1);
      wmem[4 + j] = diag(j, 1);
    end
    @(posedge clk); #2;
    do_run(1'b1, 1'b0, 1'b1, id, id);

    // Layer 1 = 2 * identity; start together with clear_all in idle.
    for (int j = 0; j < 4; j++) wmem[4 + j] = diag(j, 2);
    do_run(1'b0, 1'b1, 1'b1, id, d2);

    // All -1 weights on layer 0; 127 everywhere on layer 1 (wraps).
    imem[1] = pk(127, 127, 127, 127);
    for (int j = 0; j < 4; j++) begin
      wmem[j]     = pk(-1, -1, -1, -1);
      wmem[4 + j] = pk(127, 127, 127, 127);
    end
    do_run(1'b0, 1'b0, 1'b1, ng, wr);

    // clear_all after done zeroes results.
    clear_all = 1'b1;
    @(posedge clk); #2 clear_all = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) chk($sformatf("clear_acc%0d", j), accv[j], 0);

    // Reset at E+12 aborts; next run is normal.
    imem[1] = pk(1, 2, 3, 4);
    for (int j = 0; j < 4; j++) begin
      wmem[j]     = diag(j, 1);
      wmem[4 + j] = diag(j, 2);
    end
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", vout, 0);
    chk("abort_done", done, 0);
    chk("abort_acc0", a0, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
    do_run(1'b0, 1'b0, 1'b1, id, d2);

    // Randomized memories with full-width lanes and control noise.
    for (int r = 0; r < 25; r++) begin
      imem[0] = {$urandom, $urandom};
      imem[1] = {$urandom, $urandom};
      for (int a = 0; a < 8; a++) wmem[a] = {$urandom, $urandom};
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        clear_all = 1'($urandom_range(0, 1));
        @(posedge clk); #2 clear_all = 1'b0;
      end
      do_run(1'b1, 1'($urandom_range(0, 1)), 1'b0, zz, zz);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
